// File: rtl/wb_dpram_bridge.sv
// Wishbone B3 slave bridging single and incrementing/wrapping burst cycles onto
// one byte-lane dual-port RAM. Reads use the RAM's registered output: the read
// address runs one beat ahead of the acknowledged beat, so data is ready on ack.
module wb_dpram_bridge #(
  parameter int SIZE = 32768,
  parameter int DW   = 64,
  localparam int AW  = $clog2(SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   i_wb_adr,
  input  logic [DW-1:0] i_wb_dat,
  input  logic [7:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic [2:0]    i_wb_cti,
  input  logic [1:0]    i_wb_bte,
  output logic [DW-1:0] o_wb_rdt,
  output logic          o_wb_ack,
  output logic          o_wb_err,
  output logic [7:0]    o_ram_we,
  output logic [DW-1:0] o_ram_din,
  output logic [AW-1:0] o_ram_waddr,
  output logic [AW-1:0] o_ram_raddr,
  input  logic [DW-1:0] i_ram_dout
);

  localparam int         IW       = AW - 3;
  localparam logic [2:0] CTI_INCR = 3'b010;

  typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr_q, addr_nxt;
  logic [AW-1:0] adr_aligned, next_addr;
  logic [IW-1:0] idx, idx_inc, idx_nxt;
  logic          req, in_range;
  logic          unused_adr_lsb;

  assign req            = i_wb_cyc & i_wb_stb;
  assign adr_aligned    = {i_wb_adr[AW-1:3], 3'b000};
  assign in_range       = (i_wb_adr[31:AW] == '0);
  assign unused_adr_lsb = ^i_wb_adr[2:0];

  assign o_wb_rdt    = i_ram_dout;
  assign o_ram_din   = i_wb_dat;
  assign o_ram_waddr = addr_q;
  assign next_addr   = {idx_nxt, 3'b000};

  // Next beat index: linear wraps at the top of the RAM, wrap modes only step the low bits.
  always_comb begin
    idx     = addr_q[AW-1:3];
    idx_inc = idx + IW'(1);
    idx_nxt = idx_inc;
    case (i_wb_bte)
      2'b01:   idx_nxt = {idx[IW-1:2], idx_inc[1:0]};
      2'b10:   idx_nxt = {idx[IW-1:3], idx_inc[2:0]};
      2'b11:   idx_nxt = {idx[IW-1:4], idx_inc[3:0]};
      default: idx_nxt = idx_inc;
    endcase
  end

  // Next-state, beat address and bus/RAM strobes.
  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr_q;
    o_wb_ack    = 1'b0;
    o_wb_err    = 1'b0;
    o_ram_we    = '0;
    o_ram_raddr = addr_q;
    case (state)
      IDLE: begin
        // Prefetch the first beat so its data is on i_ram_dout in the ack cycle.
        o_ram_raddr = adr_aligned;
        if (req) begin
          if (in_range) begin
            addr_nxt  = adr_aligned;
            state_nxt = ACTIVE;
          end else begin
            state_nxt = ERR;
          end
        end
      end
      ACTIVE: begin
        o_wb_ack = req;
        if (req) begin
          o_ram_raddr = next_addr;
          if (i_wb_we) o_ram_we = i_wb_sel;
          if (i_wb_cti == CTI_INCR) addr_nxt = next_addr;
          else                      state_nxt = IDLE;
        end else if (!i_wb_cyc) begin
          state_nxt = IDLE;
        end
      end
      ERR: begin
        o_wb_err  = req;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and beat-address register; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr_q <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
    end
  end

endmodule

// File: tb/tb_wb_dpram_bridge.sv
// Bench for wb_dpram_bridge: a registered-read byte-lane RAM next to the DUT,
// a reference memory image, and burst addresses computed arithmetically.
module tb_wb_dpram_bridge;

  localparam int SIZE = 32768;
  localparam int AW   = $clog2(SIZE);
  localparam int NIDX = SIZE / 8;

  logic          clk, rst_n;
  logic [31:0]   wb_adr;
  logic [63:0]   wb_dat, wb_rdt, ram_din, ram_dout;
  logic [7:0]    wb_sel, ram_we;
  logic          wb_we, wb_cyc, wb_stb, wb_ack, wb_err;
  logic [2:0]    wb_cti;
  logic [1:0]    wb_bte;
  logic [AW-1:0] ram_waddr, ram_raddr;

  int vectors     = 0;
  int miscompares = 0;

  logic [63:0] ram     [NIDX];
  logic [63:0] ref_mem [NIDX];
  logic        load_ram;

  // Burst request description
  int          n_beats, stall_at;
  logic [31:0] b_adr;
  logic [1:0]  b_bte;
  logic [2:0]  single_cti;
  logic        b_we  [16];
  logic [7:0]  b_sel [16];
  logic [63:0] b_dat [16];

  // Observations of the last burst
  logic          obs_ack_t0;
  logic [63:0]   obs_rdt   [16];
  logic [7:0]    obs_we    [16];
  logic [AW-1:0] obs_waddr [16];
  int            obs_bad, obs_we_cycles;

  wb_dpram_bridge #(.SIZE(SIZE), .DW(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel), .i_wb_we(wb_we),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_cti(wb_cti), .i_wb_bte(wb_bte),
    .o_wb_rdt(wb_rdt), .o_wb_ack(wb_ack), .o_wb_err(wb_err),
    .o_ram_we(ram_we), .o_ram_din(ram_din), .o_ram_waddr(ram_waddr),
    .o_ram_raddr(ram_raddr), .i_ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: byte-lane writes, registered read-first output, preloaded from ref_mem.
  always @(posedge clk) begin
    if (load_ram) begin
      for (int i = 0; i < NIDX; i++) ram[i] <= ref_mem[i];
    end else begin
      for (int b = 0; b < 8; b++)
        if (ram_we[b]) ram[ram_waddr[AW-1:3]][8*b +: 8] <= ram_din[8*b +: 8];
    end
    ram_dout <= ram[ram_raddr[AW-1:3]];
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  // Word index touched by beat k of a burst starting at byte address a.
  function automatic int beat_idx(input logic [31:0] a, input logic [1:0] bte, input int k);
    int start, len;
    start = int'(a[AW-1:3]);
    case (bte)
      2'b01:   len = 4;
      2'b10:   len = 8;
      2'b11:   len = 16;
      default: len = NIDX;
    endcase
    return (start / len) * len + (start % len + k) % len;
  endfunction

  function automatic void merge(input int i, input logic [7:0] s, input logic [63:0] d);
    for (int b = 0; b < 8; b++)
      if (s[b]) ref_mem[i][8*b +: 8] = d[8*b +: 8];
  endfunction

  task automatic drive_beat(input int k);
    wb_we  = b_we[k];
    wb_sel = b_sel[k];
    wb_dat = b_dat[k];
    wb_bte = b_bte;
    if (n_beats == 1)          wb_cti = single_cti;
    else if (k == n_beats - 1) wb_cti = 3'b111;
    else                       wb_cti = 3'b010;
  endtask

  // Runs one burst as master, recording what the DUT presented on each beat.
  task automatic bus_burst();
    int k, stalls;
    k = 0; stalls = 0; obs_bad = 0; obs_we_cycles = 0;
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = b_adr;
    drive_beat(0);
    @(negedge clk);
    obs_ack_t0 = wb_ack | wb_err;
    if (ram_we != 0) obs_we_cycles++;
    @(posedge clk); #1;
    while (k < n_beats) begin
      @(negedge clk);
      if (ram_we != 0) obs_we_cycles++;
      if (wb_stb) begin
        if (wb_ack !== 1'b1 || wb_err !== 1'b0) obs_bad++;
        obs_rdt[k]   = wb_rdt;
        obs_we[k]    = ram_we;
        obs_waddr[k] = ram_waddr;
        k++;
      end else if (wb_ack !== 1'b0) begin
        obs_bad++;
      end
      @(posedge clk); #1;
      if (k == n_beats) begin
        wb_cyc = 1'b0; wb_stb = 1'b0;
      end else if (k == stall_at && stalls < 2) begin
        wb_stb = 1'b0; stalls++;
      end else begin
        wb_stb = 1'b1; wb_adr = $urandom;
        drive_beat(k);
      end
    end
    @(negedge clk);
    if (wb_ack !== 1'b0 || ram_we !== 8'h00) obs_bad++;
  endtask

  task automatic test_reset();
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_sel = 8'hFF; wb_adr = 32'h10; wb_dat = {$urandom, $urandom};
    @(negedge clk); @(negedge clk);
    vectors++; if (wb_ack !== 1'b0) begin miscompares++; $display("FAIL rst_ack got=%b exp=0", wb_ack); end
    vectors++; if (wb_err !== 1'b0) begin miscompares++; $display("FAIL rst_err got=%b exp=0", wb_err); end
    vectors++; if (ram_we !== 8'h00) begin miscompares++; $display("FAIL rst_we got=%h exp=00", ram_we); end
    vectors++; if (ram_waddr !== '0) begin miscompares++; $display("FAIL rst_waddr got=%h exp=0", ram_waddr); end
    load_ram = 1'b0;
    rst_n = 1'b1; #1;
    vectors++; if (wb_ack !== 1'b0) begin miscompares++; $display("FAIL rst_release_ack got=%b exp=0", wb_ack); end
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
  endtask

  task automatic test_single();
    n_beats = 1; b_adr = 32'h10; b_bte = 2'b00; stall_at = 99; single_cti = 3'b000;
    b_we[0] = 1; b_sel[0] = 8'hFF; b_dat[0] = 64'h1122334455667788;
    bus_burst();
    vectors++; if (obs_ack_t0 !== 1'b0) begin miscompares++; $display("FAIL single_wr_t0 got=%b exp=0", obs_ack_t0); end
    vectors++; if (obs_bad != 0) begin miscompares++; $display("FAIL single_wr_ack bad_cycles=%0d exp=0", obs_bad); end
    vectors++; if (obs_we[0] !== 8'hFF) begin miscompares++; $display("FAIL single_wr_we got=%h exp=ff", obs_we[0]); end
    vectors++; if (obs_waddr[0] !== AW'(16)) begin miscompares++; $display("FAIL single_wr_waddr got=%h exp=10", obs_waddr[0]); end
    vectors++; if (obs_we_cycles != 1) begin miscompares++; $display("FAIL single_wr_we_cycles got=%0d exp=1", obs_we_cycles); end
    merge(2, 8'hFF, 64'h1122334455667788);
    b_we[0] = 0;
    bus_burst();
    vectors++; if (obs_bad != 0 || obs_ack_t0 !== 1'b0) begin miscompares++; $display("FAIL single_rd_ack bad=%0d t0=%b exp=0/0", obs_bad, obs_ack_t0); end
    vectors++; if (obs_rdt[0] !== 64'h1122334455667788) begin miscompares++; $display("FAIL single_rd_data got=%h exp=1122334455667788", obs_rdt[0]); end
  endtask

  task automatic test_byte_write();
    n_beats = 1; b_adr = 32'h10; b_bte = 2'b00; stall_at = 99; single_cti = 3'b111;
    b_we[0] = 1; b_sel[0] = 8'h01; b_dat[0] = 64'hAA;
    bus_burst();
    vectors++; if (obs_we[0] !== 8'h01) begin miscompares++; $display("FAIL byte_wr_we got=%h exp=01", obs_we[0]); end
    merge(2, 8'h01, 64'hAA);
    b_we[0] = 0;
    bus_burst();
    vectors++; if (obs_rdt[0] !== 64'h11223344556677AA) begin miscompares++; $display("FAIL byte_rd_data got=%h exp=11223344556677aa", obs_rdt[0]); end
  endtask

  task automatic test_linear_read();
    logic [31:0] starts [2];
    starts[0] = 32'h100; starts[1] = SIZE - 16;
    for (int s = 0; s < 2; s++) begin
      n_beats = 4; b_adr = starts[s]; b_bte = 2'b00; stall_at = 99;
      for (int k = 0; k < 4; k++) begin b_we[k] = 0; b_sel[k] = 8'hFF; b_dat[k] = '0; end
      bus_burst();
      vectors++; if (obs_ack_t0 !== 1'b0 || obs_bad != 0) begin miscompares++; $display("FAIL lin_rd_acks start=%h t0=%b bad=%0d exp=0/0", starts[s], obs_ack_t0, obs_bad); end
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (obs_rdt[k] !== ref_mem[beat_idx(b_adr, 2'b00, k)]) begin
          miscompares++; $display("FAIL lin_rd_data start=%h beat=%0d got=%h exp=%h", starts[s], k, obs_rdt[k], ref_mem[beat_idx(b_adr, 2'b00, k)]);
        end
      end
    end
  endtask

  task automatic test_wrap4_write();
    n_beats = 4; b_adr = 32'h118; b_bte = 2'b01; stall_at = 99;
    for (int k = 0; k < 4; k++) begin b_we[k] = 1; b_sel[k] = 8'hFF; b_dat[k] = {$urandom, $urandom}; end
    bus_burst();
    vectors++; if (obs_bad != 0) begin miscompares++; $display("FAIL wrap4_acks bad=%0d exp=0", obs_bad); end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (obs_waddr[k] !== AW'(beat_idx(b_adr, b_bte, k) * 8)) begin
        miscompares++; $display("FAIL wrap4_waddr beat=%0d got=%h exp=%h", k, obs_waddr[k], beat_idx(b_adr, b_bte, k) * 8);
      end
      merge(beat_idx(b_adr, b_bte, k), b_sel[k], b_dat[k]);
    end
    n_beats = 5; b_adr = 32'h100; b_bte = 2'b00;
    for (int k = 0; k < 5; k++) b_we[k] = 0;
    bus_burst();
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (obs_rdt[k] !== ref_mem[32 + k]) begin
        miscompares++; $display("FAIL wrap4_readback addr=%h got=%h exp=%h", 32'h100 + 8 * k, obs_rdt[k], ref_mem[32 + k]);
      end
    end
  endtask

  task automatic test_stall();
    n_beats = 4; b_adr = 32'($urandom_range(0, SIZE - 1)) & 32'hFFFF_FFF8; b_bte = 2'b10; stall_at = 1;
    for (int k = 0; k < 4; k++) b_we[k] = 0;
    bus_burst();
    vectors++; if (obs_bad != 0) begin miscompares++; $display("FAIL stall_acks bad=%0d exp=0", obs_bad); end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (obs_rdt[k] !== ref_mem[beat_idx(b_adr, b_bte, k)]) begin
        miscompares++; $display("FAIL stall_data beat=%0d got=%h exp=%h", k, obs_rdt[k], ref_mem[beat_idx(b_adr, b_bte, k)]);
      end
    end
  endtask

  task automatic test_error();
    @(posedge clk); #1;
    wb_cyc = 1; wb_stb = 1; wb_adr = SIZE; wb_we = 1; wb_sel = 8'hFF; wb_dat = {$urandom, $urandom}; wb_cti = 3'b000;
    @(negedge clk);
    vectors++; if (wb_err !== 1'b0 || wb_ack !== 1'b0) begin miscompares++; $display("FAIL err_t0 got err=%b ack=%b exp=0/0", wb_err, wb_ack); end
    @(posedge clk); #1; @(negedge clk);
    vectors++; if (wb_err !== 1'b1) begin miscompares++; $display("FAIL err_t1 got=%b exp=1", wb_err); end
    vectors++; if (wb_ack !== 1'b0 || ram_we !== 8'h00) begin miscompares++; $display("FAIL err_t1_ackwe got ack=%b we=%h exp=0/00", wb_ack, ram_we); end
    @(posedge clk); #1; @(negedge clk);
    vectors++; if (wb_err !== 1'b0 || wb_ack !== 1'b0) begin miscompares++; $display("FAIL err_oneshot got err=%b ack=%b exp=0/0", wb_err, wb_ack); end
    @(posedge clk); #1;
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
    n_beats = 1; b_adr = 32'h0; stall_at = 99; single_cti = 3'b000; b_we[0] = 0;
    bus_burst();
    vectors++; if (obs_rdt[0] !== ref_mem[0] || obs_bad != 0) begin miscompares++; $display("FAIL err_nowrite got=%h exp=%h bad=%0d", obs_rdt[0], ref_mem[0], obs_bad); end
  endtask

  task automatic test_reset_mid_burst();
    logic [63:0] d0, d1;
    d0 = {$urandom, $urandom}; d1 = ~d0;
    @(posedge clk); #1;
    wb_cyc = 1; wb_stb = 1; wb_adr = 32'h200; wb_we = 1; wb_sel = 8'hFF; wb_dat = d0; wb_cti = 3'b010; wb_bte = 2'b00;
    @(posedge clk); #1; @(negedge clk);
    vectors++; if (wb_ack !== 1'b1) begin miscompares++; $display("FAIL rstmid_beat0_ack got=%b exp=1", wb_ack); end
    merge(64, 8'hFF, d0);
    @(posedge clk); #1;
    wb_dat = d1;
    #2; rst_n = 0; #1;
    vectors++; if (wb_ack !== 1'b0 || ram_we !== 8'h00) begin miscompares++; $display("FAIL rstmid_abort got ack=%b we=%h exp=0/00", wb_ack, ram_we); end
    vectors++; if (ram_waddr !== '0) begin miscompares++; $display("FAIL rstmid_addr got=%h exp=0", ram_waddr); end
    @(posedge clk); #1;
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
    @(negedge clk); rst_n = 1;
    n_beats = 2; b_adr = 32'h200; b_bte = 2'b00; stall_at = 99; b_we[0] = 0; b_we[1] = 0;
    bus_burst();
    vectors++; if (obs_ack_t0 !== 1'b0 || obs_bad != 0) begin miscompares++; $display("FAIL rstmid_after t0=%b bad=%0d exp=0/0", obs_ack_t0, obs_bad); end
    vectors++; if (obs_rdt[0] !== ref_mem[64]) begin miscompares++; $display("FAIL rstmid_beat0 got=%h exp=%h", obs_rdt[0], ref_mem[64]); end
    vectors++; if (obs_rdt[1] !== ref_mem[65]) begin miscompares++; $display("FAIL rstmid_beat1 got=%h exp=%h", obs_rdt[1], ref_mem[65]); end
  endtask

  task automatic test_random();
    int nw, idx;
    for (int t = 0; t < 40; t++) begin
      n_beats  = $urandom_range(1, 8);
      b_bte    = 2'($urandom_range(0, 3));
      b_adr    = 32'($urandom_range(0, SIZE - 1)) & 32'hFFFF_FFF8;
      stall_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n_beats) : 99;
      case ($urandom_range(0, 3))
        0:       single_cti = 3'b000;
        1:       single_cti = 3'b111;
        2:       single_cti = 3'b001;
        default: single_cti = 3'b110;
      endcase
      nw = 0;
      for (int k = 0; k < n_beats; k++) begin
        b_we[k]  = 1'($urandom_range(0, 1));
        b_sel[k] = 8'($urandom_range(1, 255));
        b_dat[k] = {$urandom, $urandom};
        if (b_we[k]) nw++;
      end
      bus_burst();
      vectors++; if (obs_ack_t0 !== 1'b0 || obs_bad != 0) begin miscompares++; $display("FAIL rnd_acks t=%0d t0=%b bad=%0d exp=0/0", t, obs_ack_t0, obs_bad); end
      vectors++; if (obs_we_cycles != nw) begin miscompares++; $display("FAIL rnd_we_cycles t=%0d got=%0d exp=%0d", t, obs_we_cycles, nw); end
      for (int k = 0; k < n_beats; k++) begin
        idx = beat_idx(b_adr, b_bte, k);
        if (b_we[k]) begin
          vectors++;
          if (obs_we[k] !== b_sel[k] || obs_waddr[k] !== AW'(idx * 8)) begin
            miscompares++; $display("FAIL rnd_write t=%0d beat=%0d we=%h waddr=%h exp=%h/%h", t, k, obs_we[k], obs_waddr[k], b_sel[k], idx * 8);
          end
          merge(idx, b_sel[k], b_dat[k]);
        end else begin
          vectors++;
          if (obs_rdt[k] !== ref_mem[idx] || obs_we[k] !== 8'h00) begin
            miscompares++; $display("FAIL rnd_read t=%0d beat=%0d got=%h we=%h exp=%h/00", t, k, obs_rdt[k], obs_we[k], ref_mem[idx]);
          end
        end
      end
    end
  endtask

  initial begin
    rst_n = 0; wb_cyc = 0; wb_stb = 0; wb_adr = '0; wb_dat = '0; wb_sel = '0;
    wb_we = 0; wb_cti = '0; wb_bte = '0;
    for (int i = 0; i < NIDX; i++) ref_mem[i] = {$urandom, $urandom};
    load_ram = 1'b1;
    test_reset();
    test_single();
    test_byte_write();
    test_linear_read();
    test_wrap4_write();
    test_stall();
    test_error();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
